// File: rtl/native_timeout_slice_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | native_timeout_slice_pkg : native-bus FSM encoding, types and constants   |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
package native_timeout_slice_pkg;

  localparam int c_NATIVE_ADDR_W = 32;
  localparam int c_NATIVE_DATA_W = 32;
  localparam int c_NATIVE_STRB_W = c_NATIVE_DATA_W / 8;

  localparam logic [31:0] c_ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } nts_state_e;

  typedef struct packed {
    logic [c_NATIVE_ADDR_W-1:0] addr;
    logic [c_NATIVE_DATA_W-1:0] wdata;
    logic [c_NATIVE_STRB_W-1:0] wstrb;
  } native_req_t;

endpackage
`default_nettype wire

// File: rtl/native_timeout_slice.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | native_timeout_slice : registered native-bus stage with response timeout  |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module native_timeout_slice
  import native_timeout_slice_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = c_NATIVE_ADDR_W,
  parameter int                    DATA_WIDTH     = c_NATIVE_DATA_W,
  parameter int                    STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(c_ERR_DATA)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_native_valid,
  output logic                  s_native_ready,
  input  logic [ADDR_WIDTH-1:0] s_native_addr,
  input  logic [DATA_WIDTH-1:0] s_native_wdata,
  input  logic [STRB_WIDTH-1:0] s_native_wstrb,
  output logic [DATA_WIDTH-1:0] s_native_rdata,
  output logic                  m_native_valid,
  input  logic                  m_native_ready,
  output logic [ADDR_WIDTH-1:0] m_native_addr,
  output logic [DATA_WIDTH-1:0] m_native_wdata,
  output logic [STRB_WIDTH-1:0] m_native_wstrb,
  input  logic [DATA_WIDTH-1:0] m_native_rdata,
  output logic                  timeout_err,
  output logic [ADDR_WIDTH-1:0] timeout_addr,
  input  logic                  timeout_clr
);

  // Same layout as the package request type, sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
  } req_t;

  localparam int c_CNT_W = (TIMEOUT_CYCLES <= 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST =
    (TIMEOUT_CYCLES <= 0) ? '0 : c_CNT_W'(TIMEOUT_CYCLES - 1);

  nts_state_e             r_state;
  nts_state_e             w_state_nxt;
  req_t                   r_req;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic                   r_s_ready;
  logic                   r_m_valid;
  logic                   r_to_err;
  logic [ADDR_WIDTH-1:0]  r_to_addr;
  logic                   w_to_last;
  logic                   w_to_hit;

  assign w_to_last = (TIMEOUT_CYCLES != 0) && (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A downstream answer in the timeout cycle still counts as a normal completion.
  always_comb begin
    w_state_nxt = r_state;
    w_to_hit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_native_valid) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (m_native_ready) begin
          w_state_nxt = ST_RESP;
        end else if (w_to_last) begin
          w_to_hit    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req     <= '0;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_to_err  <= 1'b0;
      r_to_addr <= '0;
    end else begin
      r_m_valid <= (w_state_nxt == ST_REQ);
      r_s_ready <= (w_state_nxt == ST_RESP);

      if ((r_state == ST_IDLE) && s_native_valid) begin
        r_req <= '{addr: s_native_addr, wdata: s_native_wdata, wstrb: s_native_wstrb};
        r_cnt <= '0;
      end

      if (r_state == ST_REQ) begin
        if (m_native_ready) begin
          r_rdata <= m_native_rdata;
        end else if (w_to_hit) begin
          r_rdata <= ERR_DATA;
        end else if (r_cnt != {c_CNT_W{1'b1}}) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      // A clear arriving with a new timeout re-arms the capture, so that timeout's address is kept.
      if (w_to_hit) begin
        r_to_err <= 1'b1;
        if (!r_to_err || timeout_clr) begin
          r_to_addr <= r_req.addr;
        end
      end else if (timeout_clr) begin
        r_to_err <= 1'b0;
      end
    end
  end

  assign s_native_ready = r_s_ready;
  assign s_native_rdata = r_rdata;
  assign m_native_valid = r_m_valid;
  assign m_native_addr  = r_req.addr;
  assign m_native_wdata = r_req.wdata;
  assign m_native_wstrb = r_req.wstrb;
  assign timeout_err    = r_to_err;
  assign timeout_addr   = r_to_addr;

endmodule
`default_nettype wire

// File: tb/tb_native_timeout_slice.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_native_timeout_slice : transaction-level model bench for the slice     |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_native_timeout_slice;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_native_valid;
  logic        s_native_ready;
  logic [31:0] s_native_addr;
  logic [31:0] s_native_wdata;
  logic [3:0]  s_native_wstrb;
  logic [31:0] s_native_rdata;
  logic        m_native_valid;
  logic        m_native_ready;
  logic [31:0] m_native_addr;
  logic [31:0] m_native_wdata;
  logic [3:0]  m_native_wstrb;
  logic [31:0] m_native_rdata;
  logic        timeout_err;
  logic [31:0] timeout_addr;
  logic        timeout_clr;

  native_timeout_slice #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
    .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_native_valid(s_native_valid), .s_native_ready(s_native_ready),
    .s_native_addr(s_native_addr), .s_native_wdata(s_native_wdata),
    .s_native_wstrb(s_native_wstrb), .s_native_rdata(s_native_rdata),
    .m_native_valid(m_native_valid), .m_native_ready(m_native_ready),
    .m_native_addr(m_native_addr), .m_native_wdata(m_native_wdata),
    .m_native_wstrb(m_native_wstrb), .m_native_rdata(m_native_rdata),
    .timeout_err(timeout_err), .timeout_addr(timeout_addr), .timeout_clr(timeout_clr)
  );

  initial forever #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected per-cycle view and sticky model state.
  bit          exp_mv    = 1'b0;
  bit          exp_sr    = 1'b0;
  logic [31:0] exp_addr  = '0;
  logic [31:0] exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  logic [31:0] mdl_rdata = '0;
  bit          mdl_err   = 1'b0;
  logic [31:0] mdl_taddr = '0;
  bit          clr_en    = 1'b0;

  int sr_count    = 0;
  int sr_last_cyc = -1;
  int mv_rise_cyc = -1;
  bit mv_prev     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    chk("m_native_valid", 32'(m_native_valid), 32'(exp_mv));
    chk("s_native_ready", 32'(s_native_ready), 32'(exp_sr));
    chk("m_native_addr",  m_native_addr,       exp_addr);
    chk("m_native_wdata", m_native_wdata,      exp_wdata);
    chk("m_native_wstrb", 32'(m_native_wstrb), 32'(exp_wstrb));
    chk("s_native_rdata", s_native_rdata,      mdl_rdata);
    chk("timeout_err",    32'(timeout_err),    32'(mdl_err));
    chk("timeout_addr",   timeout_addr,        mdl_taddr);
    if (s_native_ready) begin
      sr_count++;
      sr_last_cyc = cyc;
    end
    if (m_native_valid && !mv_prev) mv_rise_cyc = cyc;
    mv_prev = m_native_valid;
  end

  // Advance one clock; apply the sticky-flag rule to the cycle that just ended.
  task automatic step(input bit hit, input logic [31:0] a);
    @(posedge clk);
    if (hit) begin
      if (!mdl_err || timeout_clr) mdl_taddr = a;
      mdl_err = 1'b1;
    end else if (timeout_clr) begin
      mdl_err = 1'b0;
    end
    #1;
    m_native_ready = 1'b0;
    timeout_clr    = clr_en && ($urandom_range(0, 7) == 0);
  endtask

  // One transaction: dly = REQ cycles before downstream ready, negative = never.
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input int dly, input logic [31:0] ds, input bit clr_hit,
                     input bit late, output int c0);
    bit tmo;
    int len;
    tmo = (dly < 0) || (dly >= TO);
    len = tmo ? TO : dly + 1;
    c0  = cyc;
    s_native_valid = 1'b1;
    s_native_addr  = a;
    s_native_wdata = wd;
    s_native_wstrb = ws;
    for (int j = 0; j < len; j++) begin
      step(1'b0, 32'h0);
      exp_mv = 1'b1; exp_sr = 1'b0;
      exp_addr = a; exp_wdata = wd; exp_wstrb = ws;
      s_native_addr  = $urandom;
      s_native_wdata = $urandom;
      s_native_wstrb = 4'($urandom);
      m_native_ready = (j == dly);
      m_native_rdata = (j == dly) ? ds : $urandom;
      if (clr_hit && tmo && (j == len - 1)) timeout_clr = 1'b1;
    end
    step(tmo, a);
    exp_mv = 1'b0; exp_sr = 1'b1;
    mdl_rdata = tmo ? ERR : ds;
    m_native_ready = late;
    m_native_rdata = $urandom;
    step(1'b0, 32'h0);
    exp_sr = 1'b0;
    s_native_valid = 1'b0;
    m_native_ready = late;
  endtask

  initial begin
    int c0;
    int sr0;
    rst_n = 1'b1;
    s_native_valid = 1'b0; s_native_addr = '0; s_native_wdata = '0; s_native_wstrb = '0;
    m_native_ready = 1'b0; m_native_rdata = '0; timeout_clr = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 32'h0);

    // Read, ready after two wait cycles.
    txn(32'h40, 32'h0, 4'h0, 2, 32'h12345678, 1'b0, 1'b0, c0);
    chk("rd_mvalid_cycle", 32'(mv_rise_cyc - c0), 32'd1);
    chk("rd_sready_cycle", 32'(sr_last_cyc - c0), 32'd4);
    chk("rd_rdata", s_native_rdata, 32'h12345678);
    chk("rd_err", 32'(timeout_err), 32'd0);

    // Write with upstream payload scrambled during REQ.
    sr0 = sr_count;
    txn(32'h44, 32'hA5A5A5A5, 4'hF, 0, 32'h0, 1'b0, 1'b0, c0);
    step(1'b0, 32'h0);
    chk("wr_wdata_held", m_native_wdata, 32'hA5A5A5A5);
    chk("wr_one_pulse", 32'(sr_count - sr0), 32'd1);

    // Timeout, then a second timeout keeps the first address.
    txn(32'h100, 32'h0, 4'h0, -1, 32'h0, 1'b0, 1'b0, c0);
    chk("to_sready_cycle", 32'(sr_last_cyc - c0), 32'd9);
    chk("to_rdata", s_native_rdata, 32'hDEADBEEF);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_addr", timeout_addr, 32'h100);
    txn(32'h200, 32'h0, 4'h0, -1, 32'h0, 1'b0, 1'b0, c0);
    chk("to2_addr_kept", timeout_addr, 32'h100);

    // Clear coinciding with a new timeout, then a clear in a quiet cycle.
    txn(32'h300, 32'h0, 4'h0, -1, 32'h0, 1'b1, 1'b0, c0);
    chk("clr_set_err", 32'(timeout_err), 32'd1);
    chk("clr_set_addr", timeout_addr, 32'h300);
    timeout_clr = 1'b1;
    step(1'b0, 32'h0);
    chk("clr_quiet_err", 32'(timeout_err), 32'd0);

    // Late ready after a forced completion, then ready on the timeout cycle.
    sr0 = sr_count;
    txn(32'h400, 32'h0, 4'h0, -1, 32'h0, 1'b0, 1'b1, c0);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    chk("late_one_pulse", 32'(sr_count - sr0), 32'd1);
    txn(32'h500, 32'h0, 4'h0, TO - 1, 32'hCAFEF00D, 1'b0, 1'b0, c0);
    chk("edge_rdata", s_native_rdata, 32'hCAFEF00D);
    chk("edge_err_kept", 32'(timeout_err), 32'd1);

    // Asynchronous reset while in REQ.
    s_native_valid = 1'b1; s_native_addr = 32'h600; s_native_wdata = 32'h0; s_native_wstrb = 4'h0;
    step(1'b0, 32'h0);
    exp_mv = 1'b1; exp_addr = 32'h600; exp_wdata = 32'h0; exp_wstrb = 4'h0;
    step(1'b0, 32'h0);
    #2 rst_n = 1'b0;
    exp_mv = 1'b0; exp_sr = 1'b0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
    mdl_rdata = '0; mdl_err = 1'b0; mdl_taddr = '0;
    s_native_valid = 1'b0;
    sr0 = sr_count;
    #1 chk("rst_mvalid_now", 32'(m_native_valid), 32'd0);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    rst_n = 1'b1;
    step(1'b0, 32'h0);
    chk("rst_no_sready", 32'(sr_count - sr0), 32'd0);
    txn(32'h8, 32'h0, 4'h0, 1, 32'h0BADF00D, 1'b0, 1'b0, c0);
    chk("rst_after_rdata", s_native_rdata, 32'h0BADF00D);

    // Randomized traffic against the model.
    clr_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int r;
      int d;
      r = $urandom_range(0, 11);
      d = (r == 11) ? -1 : r;
      txn($urandom, $urandom, 4'($urandom), d, $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), c0);
      repeat ($urandom_range(0, 2)) step(1'b0, 32'h0);
    end
    clr_en = 1'b0;
    repeat (3) step(1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
